// File: rtl/snn_event_scheduler_pkg.sv
// Shared definitions for the SNN event scheduler: FSM encoding, default sizing
// and the counter load helper used by both timed states.
package snn_event_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_SETTLE  = 2'd2,
        ST_INHIBIT = 2'd3
    } state_t;

    localparam int unsigned DEF_INPUTS = 32'd42;
    localparam int unsigned DEF_N      = 32'd4;
    localparam int unsigned DEF_SETTLE = 32'd16;
    localparam int unsigned DEF_REFRAC = 32'd8;
    localparam int unsigned CNT_W      = 32'd8;

    // A timed state of N cycles counts N-1 down to 0.
    function automatic logic [CNT_W-1:0] cnt_load(input int unsigned cycles);
        return CNT_W'(cycles - 32'd1);
    endfunction

endpackage

// File: rtl/snn_event_scheduler_if.sv
// Signal bundle between the input layer / neuron level and the event scheduler.
interface snn_event_scheduler_if #(
    parameter int unsigned p_inputs = snn_event_scheduler_pkg::DEF_INPUTS,
    parameter int unsigned p_n      = snn_event_scheduler_pkg::DEF_N
);

    logic                     i_enable;
    logic [p_inputs:1]        i_event;
    logic [p_n:1]             i_spike;
    logic [p_inputs:1]        o_event;
    logic                     o_nrst_n;
    logic [$clog2(p_n)-1:0]   o_winner;
    logic                     o_winner_vld;
    logic                     o_busy;
    logic                     o_collision;

    modport slave (
        input  i_enable, i_event, i_spike,
        output o_event, o_nrst_n, o_winner, o_winner_vld, o_busy, o_collision
    );

    modport master (
        output i_enable, i_event, i_spike,
        input  o_event, o_nrst_n, o_winner, o_winner_vld, o_busy, o_collision
    );

endinterface

// File: rtl/snn_event_scheduler_prio_enc.sv
// Lowest-index priority encoder: idx is the position of the lowest set req bit.
module snn_prio_enc #(
    parameter int unsigned p_width = 32'd4,
    parameter int unsigned p_idx_w = $clog2(p_width)
) (
    input  logic [p_width-1:0] req,
    output logic [p_idx_w-1:0] idx,
    output logic               any
);

    // Scan from the top down so the lowest set bit is the last to claim idx
    always_comb begin
        idx = '0;
        any = |req;
        for (int i = int'(p_width) - 1; i >= 0; i--) begin
            idx = req[i] ? p_idx_w'(i) : idx;
        end
    end

endmodule

// File: rtl/snn_event_scheduler.sv
// Frame scheduler: gathers synapse events, issues them as one frame, waits for
// a winning spike, then holds the neuron level in reset for the refractory time.
module snn_event_scheduler
    import snn_event_scheduler_pkg::*;
#(
    parameter int unsigned p_inputs = DEF_INPUTS,
    parameter int unsigned p_n      = DEF_N,
    parameter int unsigned p_settle = DEF_SETTLE,
    parameter int unsigned p_refrac = DEF_REFRAC
) (
    input logic                  i_clk,
    input logic                  i_rst,
    snn_event_scheduler_if.slave bus
);

    localparam int unsigned      WIN_W       = $clog2(p_n);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = cnt_load(p_settle);
    localparam logic [CNT_W-1:0] REFRAC_LOAD = cnt_load(p_refrac);
    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [p_inputs:1]  pend_r, pend_s;
    logic [p_inputs:1]  clr_s;
    logic [p_inputs:1]  event_r, event_s;
    logic               nrst_n_r, nrst_n_s;
    logic [WIN_W-1:0]   winner_r, winner_s;
    logic               winner_vld_r, winner_vld_s;
    logic               busy_r, busy_s;
    logic               collision_r, collision_s;
    logic [WIN_W-1:0]   spike_idx_s;
    logic               spike_any_s;

    snn_prio_enc #(
        .p_width (p_n)
    ) u_prio_enc (
        .req (bus.i_spike),
        .idx (spike_idx_s),
        .any (spike_any_s)
    );

    // Next-state, counter and output decode
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        clr_s        = '0;
        event_s      = '0;
        winner_s     = winner_r;
        winner_vld_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (bus.i_enable && (pend_r != '0)) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // The snapshot cleared here is exactly what goes out, so an event
                // landing in this cycle survives into the next frame.
                clr_s   = pend_r;
                event_s = pend_r;
                state_s = ST_SETTLE;
                cnt_s   = SETTLE_LOAD;
            end
            ST_SETTLE: begin
                if (spike_any_s) begin
                    state_s      = ST_INHIBIT;
                    winner_s     = spike_idx_s;
                    winner_vld_s = 1'b1;
                    cnt_s        = REFRAC_LOAD;
                end else if (cnt_r == CNT_ZERO) begin
                    state_s = ST_IDLE;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            ST_INHIBIT: begin
                if (cnt_r == CNT_ZERO) begin
                    state_s = ST_IDLE;
                end else begin
                    cnt_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase

        pend_s      = (pend_r & ~clr_s) | bus.i_event;
        collision_s = collision_r | (|(bus.i_event & pend_r & ~clr_s));
        nrst_n_s    = (state_s != ST_INHIBIT);
        busy_s      = (state_s != ST_IDLE);
    end

    // State, counter, pending set and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= CNT_ZERO;
            pend_r       <= '0;
            event_r      <= '0;
            nrst_n_r     <= 1'b0;
            winner_r     <= '0;
            winner_vld_r <= 1'b0;
            busy_r       <= 1'b0;
            collision_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            pend_r       <= pend_s;
            event_r      <= event_s;
            nrst_n_r     <= nrst_n_s;
            winner_r     <= winner_s;
            winner_vld_r <= winner_vld_s;
            busy_r       <= busy_s;
            collision_r  <= collision_s;
        end
    end

    assign bus.o_event      = event_r;
    assign bus.o_nrst_n     = nrst_n_r;
    assign bus.o_winner     = winner_r;
    assign bus.o_winner_vld = winner_vld_r;
    assign bus.o_busy       = busy_r;
    assign bus.o_collision  = collision_r;

endmodule

// File: doc/snn_event_scheduler.md
SNN_EVENT_SCHEDULER -- requirements
Module: snn_event_scheduler

Interface
REQ-001 Parameter p_inputs, default 42: number of synapse event lines.
REQ-002 Parameter p_n, default 4: number of neurons in the driven neuron level.
REQ-003 Parameter p_settle, default 16: cycles to wait for spikes after an issue (1..255).
REQ-004 Parameter p_refrac, default 8: cycles the neuron level is held in reset after a winner (1..255).
REQ-005 i_clk  in  1  sole clock; all logic on its rising edge.
REQ-006 i_rst  in  1  synchronous, active-high reset.
REQ-007 i_enable  in  1  frame issue allowed when high.
REQ-008 i_event  in  [p_inputs:1]  single-cycle event pulses from the input layer.
REQ-009 i_spike  in  [p_n:1]  spike outputs of the neuron level.
REQ-010 o_event  out  [p_inputs:1]  event vector to the neuron level, one-cycle pulse per frame.
REQ-011 o_nrst_n  out  1  active-low reset to the neuron level (membrane clear).
REQ-012 o_winner  out  [$clog2(p_n)-1:0]  index (0-based) of winning neuron.
REQ-013 o_winner_vld  out  1  one-cycle strobe qualifying o_winner.
REQ-014 o_busy  out  1  high in every state except IDLE.
REQ-015 o_collision  out  1  sticky flag: an event arrived on a line already pending.

Function
REQ-016 Pending register SHALL be updated as pend <= (pend & ~clr) | i_event each cycle; clr is the snapshot taken at ISSUE, else 0.
REQ-017 An i_event bit arriving in the ISSUE cycle SHALL remain pending for the next frame.
REQ-018 o_collision SHALL set when i_event[k] & pend[k] & ~clr[k] for any k; cleared only by reset.
REQ-019 FSM states: IDLE, ISSUE, SETTLE, INHIBIT.
REQ-020 IDLE -> ISSUE when i_enable and pend != 0; otherwise stay.
REQ-021 ISSUE lasts exactly one cycle: o_event = pend (registered), then -> SETTLE with counter loaded to p_settle-1.
REQ-022 o_event SHALL be all-zero in every cycle except the cycle after ISSUE is entered (registered output, latency 1 from IDLE->ISSUE decision to pulse).
REQ-023 SETTLE: if any i_spike bit high -> INHIBIT, capturing winner; else decrement; at counter 0 with no spike -> IDLE.
REQ-024 Winner SHALL be the lowest-index asserted i_spike bit; simultaneous spikes resolve by this rule.
REQ-025 o_winner_vld SHALL pulse one cycle on SETTLE->INHIBIT transition, o_winner valid same cycle and held until next winner.
REQ-026 INHIBIT: o_nrst_n low for exactly p_refrac cycles, then -> IDLE; i_spike ignored.
REQ-027 o_nrst_n SHALL be high in IDLE, ISSUE, SETTLE.
REQ-028 Spike seen in the final SETTLE cycle (counter 0) SHALL win over the timeout.
REQ-029 i_enable deassertion SHALL only block IDLE->ISSUE; a frame in progress completes.
REQ-030 Events SHALL continue to accumulate in pend during SETTLE and INHIBIT.

Reset
REQ-031 On i_rst high at a clock edge: state IDLE, pend 0, counter 0, o_event 0, o_nrst_n 0, o_winner 0, o_winner_vld 0, o_busy 0, o_collision 0.
REQ-032 o_nrst_n SHALL return high the first cycle after i_rst deasserts.
REQ-033 Reset mid-frame SHALL abandon the frame with no winner strobe and discard pending events.

Structure
REQ-034 Shared package SHALL hold the FSM state encoding and default parameter constants (42 inputs, 4 neurons).
REQ-035 Lowest-index priority encoder SHALL be a separate sub-module, snn_prio_enc, parameterised on width.
REQ-036 Counter width SHALL be 8 bits, shared between SETTLE and INHIBIT.

Verification
REQ-037 Reset, i_enable=1, pulse i_event[1],[2] -> one-cycle o_event=42'h3 two cycles later; no spike -> o_busy low after 1+16 SETTLE cycles, o_winner_vld never pulses.
REQ-038 Issue frame, drive i_spike=4'b0110 in SETTLE cycle 3 -> o_winner=1, o_winner_vld 1 cycle, o_nrst_n low exactly 8 cycles, then IDLE.
REQ-039 Pulse i_event[10] in the ISSUE cycle of a frame carrying i_event[1] -> first o_event=bit1 only, second frame o_event=bit10 only.
REQ-040 Pulse i_event[5] twice while pending (i_enable=0) -> o_collision=1 and stays 1; single o_event bit5 after i_enable=1.
REQ-041 Assert i_rst during INHIBIT with pend=bit20 -> all outputs at reset values, no later o_event for bit20.
REQ-042 i_spike=4'b1000 in last SETTLE cycle -> o_winner=3 strobe, no timeout return to IDLE.
